// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and helpers for the program-counter sequencer.
//   pc_seq_state_t : sequencer FSM states
//   step_log2()    : log2 of a power-of-two step, used to build the
//                    alignment mask applied to redirect targets
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } pc_seq_state_t;

  // Number of low PC bits that are always zero for a given step size.
  function automatic int step_log2(input int unsigned step);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < step) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cycle_watchdog.sv
// cycle_watchdog: saturating cycle counter with a fixed expiry limit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count this cycle
//   count      : current count, saturates at all-ones
//   expired    : count has reached MAX_CYCLES-1
module cycle_watchdog #(
  parameter int          CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count   = cnt_q;
  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives the PC of the datapath from START_PC to END_PC in
// steps of STEP, with stall, single-step, redirect, abort and a watchdog.
//   start          : begin a run (honoured in IDLE/DONE/TIMEOUT)
//   abort          : return to IDLE from any state
//   mode           : 0 free-run (advance unless stall), 1 single-step
//   step_req       : advance one PC in single-step mode
//   stall          : hold the PC in free-run mode
//   redirect_valid : load aligned redirect_pc as the next PC
//   pc / pc_valid  : current PC and whether it is a live address
//   done / timeout : run completed / watchdog fired (levels)
//   cycle_count    : RUN cycles in the current run, saturating
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int unsigned STEP       = 4,
  parameter int unsigned START_PC   = 0,
  parameter int unsigned END_PC     = 356,
  parameter int          CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic              step_req,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int                ALIGN_BITS = step_log2(STEP);
  localparam logic [ADDR_W-1:0] START_V    = ADDR_W'(START_PC);
  localparam logic [ADDR_W-1:0] END_V      = ADDR_W'(END_PC);
  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  pc_seq_state_t     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic advance;
  logic at_end;
  logic run_accept;
  logic wd_expired;

  assign advance    = mode ? step_req : !stall;
  assign at_end     = (pc_q == END_V);
  // A new run is accepted from any non-RUN state; abort takes precedence.
  assign run_accept = (state_q != ST_RUN) && start && !abort;

  cycle_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (run_accept),
    .en      (state_q == ST_RUN),
    .count   (cycle_count),
    .expired (wd_expired)
  );

  // State register together with the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= START_V;
      pc_valid_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (abort)                  state_d = ST_IDLE;
        else if (redirect_valid)    state_d = ST_RUN;
        else if (at_end && advance) state_d = ST_DONE;
        else if (wd_expired)        state_d = ST_TIMEOUT;
      end
      default: begin
        if (abort)      state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
    endcase
  end

  // Output logic: same priority order as the next-state logic.
  always_comb begin
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (abort) begin
          pc_d       = START_V;
          pc_valid_d = 1'b0;
        end else if (redirect_valid) begin
          pc_d = redirect_pc & ALIGN_MASK;
        end else if (at_end && advance) begin
          pc_valid_d = 1'b0;
          done_d     = 1'b1;
        end else if (wd_expired) begin
          pc_valid_d = 1'b0;
          timeout_d  = 1'b1;
        end else if (advance) begin
          pc_d = pc_q + STEP_V;  // wraps silently modulo 2^ADDR_W
        end
      end
      default: begin
        if (abort || start) begin
          pc_d       = START_V;
          pc_valid_d = !abort;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end
    endcase
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer with default parameters
// and of an 8-bit instance whose run wraps through zero.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8, abort, mode, step_req, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  redirect_pc8;

  logic [31:0] pc;
  logic        pc_valid, done, timeout;
  logic [15:0] cycle_count;

  logic [7:0]  pc8;
  logic        pc_valid8, done8, timeout8;
  logic [15:0] cycle_count8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .step_req       (step_req),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .done           (done),
    .timeout        (timeout),
    .cycle_count    (cycle_count)
  );

  pc_sequencer #(
    .ADDR_W   (8),
    .START_PC (248),
    .END_PC   (8)
  ) dut8 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start8),
    .abort          (abort),
    .mode           (mode),
    .step_req       (step_req),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc8),
    .pc             (pc8),
    .pc_valid       (pc_valid8),
    .done           (done8),
    .timeout        (timeout8),
    .cycle_count    (cycle_count8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          pulses;
    logic [7:0]  exp8 [5];
    exp8[0] = 8'd248; exp8[1] = 8'd252; exp8[2] = 8'd0; exp8[3] = 8'd4; exp8[4] = 8'd8;

    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; abort = 1'b0; mode = 1'b0;
    step_req = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; redirect_pc8 = 8'h0;

    // Reset state
    tick(); tick();
    chk("rst_pc", pc, 0);
    chk("rst_valid", pc_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", cycle_count, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", pc_valid, 0);

    // Free run 0..356
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 90; i++) begin
      chk("free_pc", pc, 32'(4 * i));
      chk("free_valid", pc_valid, 1);
      chk("free_done", done, 0);
      tick();
    end
    chk("free_done_end", done, 1);
    chk("free_valid_end", pc_valid, 0);
    chk("free_pc_end", pc, 356);
    chk("free_count_end", cycle_count, 90);
    tick();
    chk("free_pc_hold", pc, 356);
    chk("free_done_hold", done, 1);
    $display("free-run: done at 90 RUN cycles, count=%0d", cycle_count);

    // Stall for 3 cycles at pc=40
    start = 1'b1; tick(); start = 1'b0;
    chk("stall_done_clr", done, 0);
    for (int c = 0; c < 93; c++) begin
      if (c <= 10)      exp_pc = 32'(4 * c);
      else if (c <= 13) exp_pc = 32'd40;
      else              exp_pc = 32'(4 * (c - 3));
      chk("stall_pc", pc, exp_pc);
      chk("stall_done", done, 0);
      stall = (c >= 10 && c <= 12);
      tick();
    end
    stall = 1'b0;
    chk("stall_done_end", done, 1);
    chk("stall_count_end", cycle_count, 93);
    $display("stall: done after 93 RUN cycles, count=%0d", cycle_count);

    // Single-step with step_req every 5th cycle; stall is ignored here
    mode = 1'b1; stall = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      chk("step_pc", pc, 32'(4 * pulses));
      chk("step_valid", pc_valid, 1);
      step_req = ((c % 5) == 4);
      if (step_req) pulses++;
      tick();
    end
    step_req = 1'b0;
    chk("step_pc_final", pc, 16);
    $display("single-step: pc=%0h after %0d pulses", pc, pulses);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_valid", pc_valid, 0);
    chk("abort_pc", pc, 0);
    mode = 1'b0; stall = 1'b0;

    // Redirect to 0x102 at pc=20: runs on to END_PC from 0x100
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("redir_pre_pc", pc, 20);
    redirect_valid = 1'b1; redirect_pc = 32'h102; tick(); redirect_valid = 1'b0;
    chk("redir_pc0", pc, 32'h100);
    tick();
    chk("redir_pc1", pc, 32'h104);
    for (int c = 0; c < 24; c++) tick();
    chk("redir_pc_last", pc, 356);
    chk("redir_valid_last", pc_valid, 1);
    tick();
    chk("redir_done", done, 1);
    chk("redir_count", cycle_count, 32);
    $display("redirect 0x102: done, count=%0d", cycle_count);

    // Redirect past END_PC: watchdog fires
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h202; tick(); redirect_valid = 1'b0;
    chk("to_redir_pc", pc, 32'h200);
    for (int c = 6; c < 1023; c++) tick();
    chk("to_count", cycle_count, 1023);
    chk("to_pc_pre", pc, 32'h200 + 32'(4 * 1017));
    chk("to_pre_timeout", timeout, 0);
    chk("to_pre_valid", pc_valid, 1);
    tick();
    chk("to_timeout", timeout, 1);
    chk("to_valid", pc_valid, 0);
    chk("to_done", done, 0);
    chk("to_pc_held", pc, 32'h200 + 32'(4 * 1017));
    $display("timeout: fired after count 1023, pc=%0h", pc);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("abort_start_timeout", timeout, 0);
    chk("abort_start_valid", pc_valid, 0);

    // Asynchronous reset mid-run at pc=200
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 50; c++) tick();
    chk("arst_pre_pc", pc, 200);
    rst_n = 1'b0; #1;
    chk("arst_pc", pc, 0);
    chk("arst_valid", pc_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_count", cycle_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_hold_pc", pc, 0);
    chk("arst_hold_valid", pc_valid, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("arst_restart_valid", pc_valid, 1);
    $display("async reset: outputs cleared, restart pc=%0h", pc);

    // 8-bit instance wrapping 248 -> 8
    start8 = 1'b1; tick(); start8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("w8_pc", pc8, exp8[i]);
      chk("w8_valid", pc_valid8, 1);
      tick();
    end
    chk("w8_done", done8, 1);
    chk("w8_valid_end", pc_valid8, 0);
    chk("w8_pc_end", pc8, 8);
    chk("w8_count", cycle_count8, 5);
    $display("8-bit wrap: done after %0d cycles", cycle_count8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
